// File: rtl/mod7_divider_pkg.sv
// mod7_pkg: shared FSM state type, modulus/iteration constants and residue canonicalisation
package mod7_pkg;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic [2:0] MOD7 = 3'd7;
  localparam int N_ITER = 5;
  function automatic logic [2:0] canon7(input logic [2:0] x);
    return (x == MOD7) ? 3'd0 : x;
  endfunction
endpackage

// File: rtl/mod7_divider_if.sv
// mod7_divider_if: operand/result valid-ready bundle (in_valid,a,b,out_ready from master; in_ready,out_valid,q,div_by_zero from slave)
interface mod7_divider_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] q;
  logic       div_by_zero;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, q, div_by_zero);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, q, div_by_zero);
endinterface

// File: rtl/mod7_divider_mul.sv
// mod7_mul: combinational residue product i_x*i_y mod 7 -> o_p (canonical 0..6), plus HalfAdder/FullAdder cells
module HalfAdder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module mod7_mul (
  input  logic [2:0] i_x,
  input  logic [2:0] i_y,
  output logic [2:0] o_p
);
  logic [5:0] w_p;
  logic       w_c1, w_s2, w_c2a, w_c2b, w_s3, w_c3a, w_c3b;
  logic [3:0] w_s;
  logic [2:0] w_t;
  assign w_p[0] = i_x[0] & i_y[0];
  HalfAdder u_h1 (.i_a(i_x[1] & i_y[0]), .i_b(i_x[0] & i_y[1]), .o_s(w_p[1]), .o_c(w_c1));
  FullAdder u_f2 (.i_a(i_x[2] & i_y[0]), .i_b(i_x[1] & i_y[1]), .i_c(i_x[0] & i_y[2]), .o_s(w_s2), .o_c(w_c2a));
  HalfAdder u_h2 (.i_a(w_s2), .i_b(w_c1), .o_s(w_p[2]), .o_c(w_c2b));
  FullAdder u_f3 (.i_a(i_x[2] & i_y[1]), .i_b(i_x[1] & i_y[2]), .i_c(w_c2a), .o_s(w_s3), .o_c(w_c3a));
  HalfAdder u_h3 (.i_a(w_s3), .i_b(w_c2b), .o_s(w_p[3]), .o_c(w_c3b));
  FullAdder u_f4 (.i_a(i_x[2] & i_y[2]), .i_b(w_c3a), .i_c(w_c3b), .o_s(w_p[4]), .o_c(w_p[5]));
  assign w_s = {1'b0, w_p[5:3]} + {1'b0, w_p[2:0]};
  assign w_t = w_s[2:0] + {2'b00, w_s[3]};
  assign o_p = (w_t == 3'd7) ? 3'd0 : w_t;
endmodule

// File: rtl/mod7_divider.sv
// mod7_divider: sequential q=a/b mod 7 via a*b^5 over 5 shared-multiplier steps (clk, rst, io slave: valid/ready in a,b -> q,div_by_zero)
module mod7_divider
  import mod7_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mod7_divider_if.slave io
);
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [2:0] r_acc;
  logic [2:0] r_bq;
  logic       r_dz;
  logic [2:0] r_q;
  logic       r_dzo;
  logic [2:0] w_prod;
  mod7_mul u_mul (.i_x(r_acc), .i_y(r_bq), .o_p(w_prod));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_bq    <= '0;
      r_dz    <= 1'b0;
      r_q     <= '0;
      r_dzo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (io.in_valid) begin
          r_acc   <= canon7(io.a);
          r_bq    <= canon7(io.b);
          r_dz    <= canon7(io.b) == 3'd0;
          r_cnt   <= '0;
          r_state <= ITER;
        end
        ITER: begin
          r_acc <= w_prod;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(N_ITER - 1)) begin
            r_state <= DONE;
            r_q     <= r_dz ? 3'd0 : w_prod;
            r_dzo   <= r_dz;
          end
        end
        DONE: if (io.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io.in_ready    = r_state == IDLE;
  assign io.out_valid   = r_state == DONE;
  assign io.q           = r_q;
  assign io.div_by_zero = r_dzo;
endmodule
